// File: rtl/sram_responder_pkg.sv
// Shared constants for the SRAM responder slice.
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH : default request address and data widths
//   DEF_MEM_DEPTH                   : default number of SRAM words
//   SRAM_RD_LATENCY                 : accept-to-FIFO-push latency in cycles
//   SRAM_RSP_FIFO_DEPTH             : response FIFO entries (= request credits)
package sram_responder_pkg;
  localparam int DEF_ADDR_WIDTH      = 8;
  localparam int DEF_DATA_WIDTH      = 8;
  localparam int DEF_MEM_DEPTH       = 256;
  localparam int SRAM_RD_LATENCY     = 2;
  localparam int SRAM_RSP_FIFO_DEPTH = 4;

  // Index width for an n-entry array; at least one bit so depth-1 arrays stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_responder_if.sv
// Read request / response valid-ready bundle between the fetch path and the SRAM responder.
//   master : fetch side (drives request and response-ready)
//   slave  : responder side (drives request-ready and response)
interface sram_responder_if
  import sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  m_req_vld;
  logic                  m_req_rdy;
  logic [ADDR_WIDTH-1:0] m_req_addr;
  logic                  m_rsp_vld;
  logic                  m_rsp_rdy;
  logic [DATA_WIDTH-1:0] m_rsp_data;

  modport master (
    output m_req_vld, m_req_addr, m_rsp_rdy,
    input  m_req_rdy, m_rsp_vld, m_rsp_data
  );

  modport slave (
    input  m_req_vld, m_req_addr, m_rsp_rdy,
    output m_req_rdy, m_rsp_vld, m_rsp_data
  );
endinterface

// File: rtl/sram_responder_rsp_fifo.sv
// rsp_fifo: synchronous show-ahead FIFO holding read responses.
//   i_push/i_din : write an entry (ignored when full unless popping in the same cycle)
//   i_pop        : drop the head entry (ignored when empty)
//   o_dout       : head entry, forced to 0 while empty
//   o_empty/o_full : occupancy flags
module rsp_fifo
  import sram_responder_pkg::*;
#(
  parameter int DEPTH = SRAM_RSP_FIFO_DEPTH,
  parameter int WIDTH = DEF_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);
  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/sram_responder.sv
// sram_responder: memory-side responder for the fetch path read interface.
//   clk, rst_n            : clock, async active-low reset
//   bus (slave)           : read request / in-order response handshake
//   wr_en/wr_addr/wr_data : sideband write port (preload / update)
//   outstanding           : accepted requests not yet popped
//   err_oob               : sticky out-of-range access flag
// Reads sample the array on the accept edge, ride a RD_LATENCY-deep shift register and
// land in rsp_fifo. Request credits equal FIFO depth, so the FIFO cannot overflow.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH      = DEF_MEM_DEPTH,
  parameter int RD_LATENCY     = SRAM_RD_LATENCY,
  parameter int RSP_FIFO_DEPTH = SRAM_RSP_FIFO_DEPTH
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  sram_responder_if.slave                        bus,
  input  logic                                   wr_en,
  input  logic [ADDR_WIDTH-1:0]                  wr_addr,
  input  logic [DATA_WIDTH-1:0]                  wr_data,
  output logic [$clog2(RSP_FIFO_DEPTH+1)-1:0]    outstanding,
  output logic                                   err_oob
);
  localparam int CNT_W  = $clog2(RSP_FIFO_DEPTH + 1);
  localparam int MEM_AW = idx_width(MEM_DEPTH);
  localparam logic [CNT_W-1:0]    CREDITS   = CNT_W'(RSP_FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [RD_LATENCY-1:0] r_pipe_vld;
  logic [DATA_WIDTH-1:0] r_pipe_data [RD_LATENCY];
  logic [CNT_W-1:0]      r_outstanding;
  logic                  r_err_oob;

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_rd_in_range;
  logic                  w_wr_in_range;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_fifo_empty;
  logic                  w_unused_fifo_full;

  assign bus.m_req_rdy = (r_outstanding < CREDITS);
  assign bus.m_rsp_vld = !w_fifo_empty;
  assign w_accept      = bus.m_req_vld && bus.m_req_rdy;
  assign w_pop         = bus.m_rsp_vld && bus.m_rsp_rdy;
  assign w_rd_in_range = ({1'b0, bus.m_req_addr} < DEPTH_LIM);
  assign w_wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);
  assign w_rd_data     = w_rd_in_range ? r_mem[bus.m_req_addr[MEM_AW-1:0]] : '0;
  assign outstanding   = r_outstanding;
  assign err_oob       = r_err_oob;

  // Array is not reset so contents survive rst_n. Non-blocking write gives read-first
  // behaviour against the read sampled on the same edge.
  always_ff @(posedge clk) begin
    if (wr_en && w_wr_in_range) r_mem[wr_addr[MEM_AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_pipe_data[i] <= '0;
    end else begin
      r_pipe_vld[0]  <= w_accept;
      r_pipe_data[0] <= w_rd_data;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_data[i] <= r_pipe_data[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_err_oob     <= 1'b0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      if ((w_accept && !w_rd_in_range) || (wr_en && !w_wr_in_range)) r_err_oob <= 1'b1;
    end
  end

  rsp_fifo #(
    .DEPTH (RSP_FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_pipe_vld[RD_LATENCY-1]),
    .i_din   (r_pipe_data[RD_LATENCY-1]),
    .i_pop   (w_pop),
    .o_dout  (bus.m_rsp_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_unused_fifo_full)
  );
endmodule
